conv1_mp_accumulate_fire: RTL and testbench
===========================================

Name: conv1_mp_accumulate_fire

Overview:
- Downstream stage of the conv1 weight-search block; consumes its per-output-channel partial sums MP_1..MP_4 and MP_valid.
- Keeps the conv1 membrane-potential store: one signed entry per (output channel, pixel 1..4).
- Per pulse: read-modify-write with saturation, threshold compare, reset-on-fire, spike event to the conv1 output FIFO.
- At each timestep boundary: optional leak sweep, then signals completion.

Parameters:
- CONV1_CHANNEL_NUM_O, 128, number of output channels (store depth = 4*CONV1_CHANNEL_NUM_O).
- THRESHOLD, 256, signed firing threshold; fire when updated potential >= THRESHOLD.
- V_RESET, 0, potential written after a fire.
- LEAK_SHIFT, 3, leak divisor exponent (used only with CONV1_LEAK_EN).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, active-low
- MP_1..MP_4  in  `MP_WIDE each, signed  partial sums for pixels 1..4
- channel_o  in  `CONV1_CHANNEL_O_WIDE  current output channel from upstream
- MP_valid  in  1  one-cycle pulse: partial sums complete
- timestep_end  in  1  one-cycle pulse: input events of this timestep exhausted
- spike_afull  in  1  output FIFO almost-full (>=1 free entry guaranteed while low)
- spike_w_en  out  1  FIFO write strobe
- spike_data  out  `CONV1_CHANNEL_O_WIDE+2  {channel, pixel index 0..3}
- busy  out  1  pending or in-progress work
- timestep_done  out  1  one-cycle pulse: timestep processing finished
- overflow  out  1  sticky: an MP_valid was dropped

Behaviour:
- Reset:
  - Every output is 0: spike_w_en, spike_data, busy, timestep_done, overflow.
  - All store entries, the holding register, channel_d, the pending flag and the FSM (IDLE) are cleared.
  - Reset mid-operation abandons the work in progress; no partial writes survive.
- channel_d <= channel_o every cycle. Sums presented with MP_valid belong to channel_d, because upstream has already advanced channel_o.
- Holding register, 1 deep:
  - On MP_valid it captures {channel_d, MP_1..MP_4} and sets hold_full.
  - MP_valid while hold_full is set and not being consumed that same cycle: data dropped, overflow <= 1 until reset.
  - Consumption and a new capture in the same cycle are legal.
- FSM states: IDLE, UPDATE, LEAK, DONE.
- IDLE:
  - hold_full -> UPDATE with k=0, consuming the holding register into a work register.
  - Else pending timestep -> LEAK, or DONE when leak is disabled.
  - Holding work takes priority over a pending timestep.
- UPDATE, one cycle per pixel k=0..3:
  - sum = mem + MP_(k+1), computed at `MP_WIDE+1 bits and clamped to the signed `MP_WIDE range.
  - fire = (sum >= THRESHOLD).
  - If fire and spike_afull: stall. No write, k held.
  - Else write (fire ? V_RESET : sum).
  - On fire, the next cycle has spike_w_en=1 with spike_data={ch,k}.
  - k=3 completes -> IDLE.
  - Latency: MP_valid at cycle T, pixel k written at edge T+2+k, spike strobe in cycle T+3+k, assuming no stall and no queueing.
- timestep_end: sets the pending flag in any state. It is consumed on entry to LEAK/DONE. A second pulse before consumption merges into the first.
- LEAK: described under Optional Feature.
- DONE: one cycle; timestep_done=1; -> IDLE.
- busy = (state != IDLE) | hold_full | pending.
- spike_w_en is registered and only ever a single-cycle pulse per fire.

Optional Feature:
- Macro: CONV1_LEAK_EN.
- Defined:
  - LEAK sweeps all 4*CONV1_CHANNEL_NUM_O entries, one per cycle, ascending address.
  - Each entry: v <= v - (v >>> LEAK_SHIFT), arithmetic shift.
  - Sweep end -> DONE.
  - MP_valid during a sweep is captured into the holding register (overflow rules apply) and processed after DONE.
- Undefined:
  - No LEAK state or leak logic.
  - Pending timestep goes IDLE -> DONE directly; potentials persist across timesteps.

Test Plan:
- Reset, channel_o=5 then 6 with MP_valid, MP_1..4=100,-20,300,0 -> exactly one spike_data={5,2}; store[5]={100,-20,V_RESET,0}; busy drops 6 cycles after MP_valid.
- Ch3 pixel1 increment 150 in two separate MP_valid events -> first: no spike, store=150; second: spike {3,0}, store=0.
- MP_WIDE=16, two events adding -30000 to one pixel -> store=-32768 (saturated), no spike.
- Fire with spike_afull=1 for 10 cycles -> no spike_w_en, state held, store unchanged; afull low -> exactly one spike, update completes.
- CONV1_LEAK_EN, store entry=200, LEAK_SHIFT=3, timestep_end -> entry 175; timestep_done 1 cycle after the 512th sweep cycle; without macro, timestep_done 2 cycles after the pulse and entry stays 200.
- Three MP_valid on consecutive cycles while in UPDATE -> third dropped, overflow=1 and sticky until rstn.

Source files
------------

// File: rtl/conv1_mp_accumulate_fire.sv
// ---------------------------------------------------------------------------
// conv1_mp_accumulate_fire
//
// Purpose:
//   Membrane-potential accumulate-and-fire stage that sits behind the conv1
//   weight-search block. Each MP_valid pulse carries four partial sums (one
//   per pixel) for the output channel that upstream has just finished. Every
//   sum is added into its stored potential with saturation and compared to
//   THRESHOLD. A potential that crosses the threshold is replaced by V_RESET,
//   and its {channel, pixel} address is pushed to the output spike FIFO. At a
//   timestep boundary an optional leak sweep decays every stored potential,
//   and then timestep_done pulses.
//
// Build option:
//   CONV1_LEAK_EN - when defined, the timestep boundary runs a leak sweep
//                   v <= v - (v >>> LEAK_SHIFT) over all entries before
//                   timestep_done. When undefined, potentials persist.
//
// Ports:
//   clk            system clock
//   rstn           asynchronous reset, active low
//   MP_1..MP_4     signed partial sums for pixels 0..3
//   channel_o      current output channel from upstream (one cycle ahead)
//   MP_valid       one-cycle pulse, partial sums complete
//   timestep_end   one-cycle pulse, input events of the timestep exhausted
//   spike_afull    spike FIFO almost full
//   spike_w_en     spike FIFO write strobe (registered, one cycle per fire)
//   spike_data     {channel, pixel index}
//   busy           work pending or in progress
//   timestep_done  one-cycle pulse, timestep processing finished
//   overflow       sticky, an MP_valid was dropped
// ---------------------------------------------------------------------------
`ifndef MP_WIDE
`define MP_WIDE 16
`endif
`ifndef CONV1_CHANNEL_O_WIDE
`define CONV1_CHANNEL_O_WIDE 7
`endif

module conv1_mp_accumulate_fire #(
  parameter int CONV1_CHANNEL_NUM_O = 128,
  parameter int THRESHOLD           = 256,
  parameter int V_RESET             = 0,
  parameter int LEAK_SHIFT          = 3
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic signed [`MP_WIDE-1:0]           MP_1,
  input  logic signed [`MP_WIDE-1:0]           MP_2,
  input  logic signed [`MP_WIDE-1:0]           MP_3,
  input  logic signed [`MP_WIDE-1:0]           MP_4,
  input  logic [`CONV1_CHANNEL_O_WIDE-1:0]     channel_o,
  input  logic                                 MP_valid,
  input  logic                                 timestep_end,
  input  logic                                 spike_afull,
  output logic                                 spike_w_en,
  output logic [`CONV1_CHANNEL_O_WIDE+1:0]     spike_data,
  output logic                                 busy,
  output logic                                 timestep_done,
  output logic                                 overflow
);

  localparam int W     = `MP_WIDE;
  localparam int CW    = `CONV1_CHANNEL_O_WIDE;
  localparam int AW    = CW + 2;
  localparam int DEPTH = 4 * CONV1_CHANNEL_NUM_O;

  localparam logic signed [W-1:0] MP_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MP_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] V_RESET_W = V_RESET[W-1:0];

`ifdef CONV1_LEAK_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_LEAK   = 2'd2,
    S_DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [CW-1:0]       chan_dly_q;   // channel_o delayed by one cycle
  logic                hold_full_q;
  logic [CW-1:0]       hold_ch_q;
  logic signed [W-1:0] hold_mp_q [4];
  logic [CW-1:0]       work_ch_q;
  logic signed [W-1:0] work_mp_q [4];
  logic                pending_q;
  logic                overflow_q;
  logic                spike_w_en_q;
  logic [AW-1:0]       spike_data_q;
  logic signed [W-1:0] mem_q [DEPTH];

  logic signed [W-1:0] mp_in [4];
  logic [AW-1:0]       upd_addr;
  logic signed [W-1:0] upd_old;
  logic signed [W-1:0] mp_sel;
  logic signed [W:0]   sum_wide;
  logic signed [W-1:0] sum_sat;
  logic                fire;
  logic                consume;
  logic                capture;
  logic                pend_clr;
  logic                spike_set;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic signed [W-1:0] mem_wdata;

  assign mp_in[0] = MP_1;
  assign mp_in[1] = MP_2;
  assign mp_in[2] = MP_3;
  assign mp_in[3] = MP_4;

`ifdef CONV1_LEAK_EN
  localparam int            LAST_IDX  = DEPTH - 1;
  localparam logic [AW-1:0] LEAK_LAST = LAST_IDX[AW-1:0];

  logic [AW-1:0]       leak_addr_q, leak_addr_d;
  logic signed [W-1:0] leak_old;
  logic signed [W-1:0] leak_new;

  assign leak_old = mem_q[leak_addr_q];
  // Subtracting a same-signed fraction moves v toward zero, so this never
  // leaves the signed range.
  assign leak_new = leak_old - (leak_old >>> LEAK_SHIFT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      leak_addr_q <= '0;
    end else begin
      leak_addr_q <= leak_addr_d;
    end
  end
`else
  // LEAK_SHIFT only matters in the leak build; tie it off here.
  logic unused_leak_shift;
  assign unused_leak_shift = (LEAK_SHIFT != 0);
`endif

  // Update datapath: the stored entry plus the selected pixel sum, formed one
  // bit wider and then clamped back into the signed MP range.
  assign upd_addr = {work_ch_q, k_q};
  assign upd_old  = mem_q[upd_addr];
  assign mp_sel   = work_mp_q[k_q];
  assign sum_wide = {upd_old[W-1], upd_old} + {mp_sel[W-1], mp_sel};

  always_comb begin
    sum_sat = sum_wide[W-1:0];
    if (sum_wide[W] != sum_wide[W-1]) begin
      sum_sat = sum_wide[W] ? MP_MIN : MP_MAX;
    end
  end

  assign fire = (int'(sum_sat) >= THRESHOLD);

  // Next-state and control
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    consume   = 1'b0;
    pend_clr  = 1'b0;
    spike_set = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = upd_addr;
    mem_wdata = sum_sat;
`ifdef CONV1_LEAK_EN
    leak_addr_d = leak_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Queued sums are handled before a pending timestep boundary.
        if (hold_full_q) begin
          consume = 1'b1;
          k_d     = 2'd0;
          state_d = S_UPDATE;
        end else if (pending_q) begin
          pend_clr = 1'b1;
`ifdef CONV1_LEAK_EN
          leak_addr_d = '0;
          state_d     = S_LEAK;
`else
          state_d     = S_DONE;
`endif
        end
      end
      S_UPDATE: begin
        // A fire with no FIFO room holds this pixel untouched until room opens.
        if (!(fire && spike_afull)) begin
          mem_we    = 1'b1;
          mem_wdata = fire ? V_RESET_W : sum_sat;
          spike_set = fire;
          k_d       = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = S_IDLE;
          end
        end
      end
`ifdef CONV1_LEAK_EN
      S_LEAK: begin
        mem_we      = 1'b1;
        mem_waddr   = leak_addr_q;
        mem_wdata   = leak_new;
        leak_addr_d = leak_addr_q + AW'(1);
        if (leak_addr_q == LEAK_LAST) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A capture is allowed when the holding register is empty or is being
  // emptied into the work register in this same cycle.
  assign capture = MP_valid && (!hold_full_q || consume);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      chan_dly_q   <= '0;
      hold_full_q  <= 1'b0;
      hold_ch_q    <= '0;
      work_ch_q    <= '0;
      pending_q    <= 1'b0;
      overflow_q   <= 1'b0;
      spike_w_en_q <= 1'b0;
      spike_data_q <= '0;
      for (int i = 0; i < 4; i++) begin
        hold_mp_q[i] <= '0;
        work_mp_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      chan_dly_q <= channel_o;

      if (capture) begin
        hold_full_q <= 1'b1;
        hold_ch_q   <= chan_dly_q;
        for (int i = 0; i < 4; i++) begin
          hold_mp_q[i] <= mp_in[i];
        end
      end else if (consume) begin
        hold_full_q <= 1'b0;
      end

      if (MP_valid && !capture) begin
        overflow_q <= 1'b1;
      end

      if (consume) begin
        work_ch_q <= hold_ch_q;
        for (int i = 0; i < 4; i++) begin
          work_mp_q[i] <= hold_mp_q[i];
        end
      end

      // A pulse arriving in the consuming cycle re-arms rather than being lost.
      if (timestep_end) begin
        pending_q <= 1'b1;
      end else if (pend_clr) begin
        pending_q <= 1'b0;
      end

      spike_w_en_q <= spike_set;
      if (spike_set) begin
        spike_data_q <= upd_addr;
      end
    end
  end

  // Potential store: single write port, cleared on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign spike_w_en    = spike_w_en_q;
  assign spike_data    = spike_data_q;
  assign overflow      = overflow_q;
  assign timestep_done = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE) || hold_full_q || pending_q;

endmodule

// File: tb/tb_conv1_mp_accumulate_fire.sv
module tb_conv1_mp_accumulate_fire;

  localparam int NCH   = 128;
  localparam int DEPTH = 4 * NCH;
  localparam int THR   = 256;
  localparam int VRST  = 0;
  localparam int LSH   = 3;
`ifdef CONV1_LEAK_EN
  localparam int DONE_AT = DEPTH + 2;
`else
  localparam int DONE_AT = 2;
`endif

  logic               clk = 1'b0;
  logic               rstn;
  logic signed [15:0] MP_1, MP_2, MP_3, MP_4;
  logic [6:0]         channel_o;
  logic               MP_valid, timestep_end, spike_afull;
  logic               spike_w_en;
  logic [8:0]         spike_data;
  logic               busy, timestep_done, overflow;

  always #5 clk = ~clk;

  conv1_mp_accumulate_fire dut (
    .clk          (clk),
    .rstn         (rstn),
    .MP_1         (MP_1),
    .MP_2         (MP_2),
    .MP_3         (MP_3),
    .MP_4         (MP_4),
    .channel_o    (channel_o),
    .MP_valid     (MP_valid),
    .timestep_end (timestep_end),
    .spike_afull  (spike_afull),
    .spike_w_en   (spike_w_en),
    .spike_data   (spike_data),
    .busy         (busy),
    .timestep_done(timestep_done),
    .overflow     (overflow)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         spikes_seen = 0;
  int         model_mem [DEPTH];
  logic [8:0] exp_q [$];
  int         ev_ch [3];
  int         ev_mp [3][4];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: accumulate, clamp, fire at threshold, queue the spike address.
  task automatic model_event(input int ch, input int m0, input int m1,
                             input int m2, input int m3);
    int m [4];
    m = '{m0, m1, m2, m3};
    for (int k = 0; k < 4; k++) begin
      int s;
      s = clamp16(model_mem[ch*4+k] + m[k]);
      if (s >= THR) begin
        exp_q.push_back(9'(ch*4+k));
        model_mem[ch*4+k] = VRST;
      end else begin
        model_mem[ch*4+k] = s;
      end
    end
  endtask

  // Present n events on consecutive cycles; channel_o leads MP_valid by one.
  task automatic present(input int n);
    @(negedge clk);
    channel_o = 7'(ev_ch[0]);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      channel_o = (i + 1 < n) ? 7'(ev_ch[i+1]) : 7'(ev_ch[i] + 1);
      MP_valid  = 1'b1;
      MP_1 = 16'(ev_mp[i][0]);
      MP_2 = 16'(ev_mp[i][1]);
      MP_3 = 16'(ev_mp[i][2]);
      MP_4 = 16'(ev_mp[i][3]);
    end
    @(negedge clk);
    MP_valid = 1'b0;
  endtask

  task automatic send(input int ch, input int m0, input int m1, input int m2,
                      input int m3);
    ev_ch[0] = ch;
    ev_mp[0] = '{m0, m1, m2, m3};
    model_event(ch, m0, m1, m2, m3);
    present(1);
  endtask

  task automatic wait_idle(input int budget, input bit rnd_afull);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
      if (rnd_afull) spike_afull = ($urandom_range(3) == 0);
    end
    spike_afull = 1'b0;
    @(negedge clk);
    chk("idle_wait", busy, 0);
  endtask

  // Spike monitor: every strobe must match the next address the model queued.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && spike_w_en === 1'b1) begin
        spikes_seen++;
        if (exp_q.size() == 0) chk("spike_unexpected", spike_w_en, 0);
        else chk("spike_data", spike_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rstn = 1'b0; MP_valid = 1'b0; timestep_end = 1'b0; spike_afull = 1'b0;
    channel_o = '0; MP_1 = '0; MP_2 = '0; MP_3 = '0; MP_4 = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
    repeat (3) @(negedge clk);

    chk("rst_spike_w_en", spike_w_en, 0);
    chk("rst_spike_data", spike_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", timestep_done, 0);
    chk("rst_overflow", overflow, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Channel 5 event with channel_o already advanced to 6; latency check.
    ev_ch[0] = 5;
    ev_mp[0] = '{100, -20, 300, 0};
    model_event(5, 100, -20, 300, 0);
    present(1);
    chk("t1_busy_c1", busy, 1);
    for (int n = 2; n <= 6; n++) begin
      @(negedge clk);
      chk($sformatf("t1_strobe_c%0d", n), spike_w_en, (n == 5) ? 1 : 0);
      chk($sformatf("t1_busy_c%0d", n), busy, (n <= 5) ? 1 : 0);
    end
    wait_idle(20, 1'b0);
    chk("t1_spikes", spikes_seen, 1);
    chk("t1_mem0", dut.mem_q[20], 100);
    chk("t1_mem1", dut.mem_q[21], -20);
    chk("t1_mem2", dut.mem_q[22], VRST);
    chk("t1_mem3", dut.mem_q[23], 0);

    // Two sub-threshold increments that together fire.
    base = spikes_seen;
    send(3, 150, 0, 0, 0);
    wait_idle(20, 1'b0);
    chk("t2_first_nospike", spikes_seen - base, 0);
    chk("t2_first_mem", dut.mem_q[12], 150);
    send(3, 150, 0, 0, 0);
    wait_idle(20, 1'b0);
    chk("t2_second_spike", spikes_seen - base, 1);
    chk("t2_second_mem", dut.mem_q[12], VRST);

    // Negative saturation.
    base = spikes_seen;
    send(20, -30000, 0, 0, 0);
    wait_idle(20, 1'b0);
    send(20, -30000, 0, 0, 0);
    wait_idle(20, 1'b0);
    chk("t3_sat_mem", dut.mem_q[80], -32768);
    chk("t3_sat_nospike", spikes_seen - base, 0);

    // Fire stalled by a full FIFO.
    send(10, 100, 0, 0, 0);
    wait_idle(20, 1'b0);
    chk("t4_pre_mem", dut.mem_q[40], 100);
    base = spikes_seen;
    spike_afull = 1'b1;
    send(10, 200, 0, 0, 0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("t4_stall_strobe", spike_w_en, 0);
      chk("t4_stall_mem", dut.mem_q[40], 100);
      chk("t4_stall_busy", busy, 1);
    end
    spike_afull = 1'b0;
    wait_idle(20, 1'b0);
    chk("t4_one_spike", spikes_seen - base, 1);
    chk("t4_mem_reset", dut.mem_q[40], VRST);

    // Timestep boundary.
    send(30, 200, 0, 0, 0);
    wait_idle(20, 1'b0);
    timestep_end = 1'b1;
    @(negedge clk);
    timestep_end = 1'b0;
    chk("t5_done_c1", timestep_done, 0);
    for (int n = 2; n <= DONE_AT + 1; n++) begin
      @(negedge clk);
      if (n >= DONE_AT - 1)
        chk($sformatf("t5_done_c%0d", n), timestep_done, (n == DONE_AT) ? 1 : 0);
    end
    chk("t5_busy_after", busy, 0);
`ifdef CONV1_LEAK_EN
    for (int i = 0; i < DEPTH; i++) model_mem[i] = model_mem[i] - (model_mem[i] >>> LSH);
    chk("t5_leak_entry", dut.mem_q[120], 175);
    chk("t5_leak_neg", dut.mem_q[80], -28672);
`else
    chk("t5_keep_entry", dut.mem_q[120], 200);
`endif

    // Three back-to-back events: the third finds the holding register busy.
    chk("t6_ovf_pre", overflow, 0);
    for (int i = 0; i < 3; i++) begin
      ev_ch[i] = 40 + i;
      ev_mp[i] = '{10, 10, 10, 10};
    end
    model_event(40, 10, 10, 10, 10);
    model_event(41, 10, 10, 10, 10);
    present(3);
    chk("t6_ovf_set", overflow, 1);
    wait_idle(40, 1'b0);
    chk("t6_ovf_sticky", overflow, 1);
    chk("t6_ev1_mem", dut.mem_q[160], 10);
    chk("t6_ev2_mem", dut.mem_q[167], 10);
    chk("t6_dropped_mem", dut.mem_q[168], 0);

    // Randomized traffic with random FIFO back-pressure.
    for (int e = 0; e < 60; e++) begin
      int ch;
      int m [4];
      ch = int'($urandom_range(15));
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(9) == 0) m[k] = ($urandom_range(1) == 0) ? 30000 : -30000;
        else m[k] = int'($urandom_range(500)) - 200;
      end
      send(ch, m[0], m[1], m[2], m[3]);
      wait_idle(200, 1'b1);
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (dut.mem_q[a] !== 16'(model_mem[a]) || a % 64 == 0)
        chk($sformatf("rand_mem_%0d", a), dut.mem_q[a], model_mem[a]);
    end
    chk("rand_spike_q_empty", exp_q.size(), 0);
    chk("rand_ovf_sticky", overflow, 1);

    // Reset in the middle of an update.
    ev_ch[0] = 50;
    ev_mp[0] = '{100, 100, 100, 100};
    present(1);
    repeat (2) @(negedge clk);
    chk("t7_partial_written", dut.mem_q[200], 100);
    rstn = 1'b0;
    #1;
    chk("t7_rst_overflow", overflow, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_strobe", spike_w_en, 0);
    chk("t7_rst_mem200", dut.mem_q[200], 0);
    chk("t7_rst_mem20", dut.mem_q[20], 0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_idle_after", busy, 0);
    chk("t7_mem201", dut.mem_q[201], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
